// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and sizing helpers for the button debouncer array
//
// Purpose: FSM state encoding and the hold-counter width helper used by
//          btn_channel. No ports.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_HELD    = 2'd2
  } btn_state_e;

  // Width needed to hold any value 0..max(a, b).
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one debounced button: sync, sample window, hysteresis, press/hold FSM
//
// Purpose: conditions a single asynchronous button pin into a clean level plus
//          registered one-cycle event pulses. All state advances only when
//          tick_i is high; tick_i is an enable, never a clock.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   tick_i   in   sample strobe from the shared prescaler
//   btn_i    in   raw asynchronous button pin
//   level_o  out  debounced pressed state
//   rise_o   out  1-cycle pulse, press accepted
//   fall_o   out  1-cycle pulse, release accepted
//   long_o   out  1-cycle pulse, hold reached LONG_TICKS
//   rep_o    out  1-cycle pulse every REPEAT_TICKS while held past long press
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o,
  output logic rep_o
);

  localparam int            CW        = clog2_max(LONG_TICKS, REPEAT_TICKS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = (REPEAT_TICKS > 0) ? CW'(REPEAT_TICKS - 1) : '0;
  localparam logic          REPEAT_EN = (REPEAT_TICKS > 0);
  localparam logic          INV       = (ACTIVE_LOW != 0);

  logic [1:0]       sync_q;
  logic             samp;
  logic [DEPTH-1:0] win_q, win_d;
  logic             level_q, level_d;
  logic             lvl_rise, lvl_fall;
  btn_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rise_q, fall_q, long_q, long_d, rep_q, rep_d;

  // Polarity is fixed after the second flop so the synchroniser itself
  // always resets to 0 regardless of ACTIVE_LOW.
  assign samp = sync_q[1] ^ INV;

  // Level reacts on the same edge that shifts in the DEPTH-th equal sample,
  // so it is evaluated on the next window value, not the current one.
  always_comb begin
    win_d = win_q;
    if (tick_i) begin
      win_d = {win_q[DEPTH-2:0], samp};
    end
    level_d = level_q;
    if (&win_d) begin
      level_d = 1'b1;
    end else if (~|win_d) begin
      level_d = 1'b0;
    end
  end

  assign lvl_rise = level_d & ~level_q;
  assign lvl_fall = ~level_d & level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      win_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      win_q   <= win_d;
      level_q <= level_d;
      rise_q  <= lvl_rise;
      fall_q  <= lvl_fall;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BTN_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. The counter holds at threshold-1 and is cleared on the
  // tick that fires, so it never needs to represent the threshold itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BTN_IDLE: begin
        if (lvl_rise) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
        end
      end
      BTN_PRESSED: begin
        if (lvl_fall) begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == LONG_LAST) begin
            state_d = BTN_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      BTN_HELD: begin
        if (lvl_fall) begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end else if (tick_i && REPEAT_EN) begin
          if (cnt_q == REP_LAST) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = BTN_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM: outputs. A release accepted on the threshold tick suppresses the pulse.
  always_comb begin
    long_d = (state_q == BTN_PRESSED) && tick_i && !lvl_fall && (cnt_q == LONG_LAST);
    rep_d  = REPEAT_EN && (state_q == BTN_HELD) && tick_i && !lvl_fall && (cnt_q == REP_LAST);
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign long_o  = long_q;
  assign rep_o   = rep_q;

endmodule

// File: rtl/button_debouncer_array.sv
// rtl/button_debouncer_array.sv - N_CH-channel button debouncer with shared tick prescaler
//
// Purpose: shared prescaler producing a one-cycle sample strobe every
//          CLK_HZ/TICK_HZ clocks, feeding N_CH independent btn_channel instances.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high
//   in_button     in   [N_CH] raw asynchronous button pins
//   level         out  [N_CH] debounced pressed state
//   rising_edge   out  [N_CH] 1-cycle pulse on press accepted
//   falling_edge  out  [N_CH] 1-cycle pulse on release accepted
//   both_edge     out  [N_CH] rising_edge | falling_edge
//   long_press    out  [N_CH] 1-cycle pulse when hold reaches LONG_TICKS
//   repeat_pulse  out  [N_CH] 1-cycle pulse every REPEAT_TICKS after long press
//   tick          out  prescaler strobe
module button_debouncer_array
  import btn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1_000,
  parameter int DEPTH        = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in_button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rising_edge,
  output logic [N_CH-1:0] falling_edge,
  output logic [N_CH-1:0] both_edge,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            tick
);

  localparam int            DIV      = CLK_HZ / TICK_HZ;
  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (presc_q == DIV_LAST) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = (presc_q == DIV_LAST);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .DEPTH       (DEPTH),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick_i (tick),
      .btn_i  (in_button[g]),
      .level_o(level[g]),
      .rise_o (rising_edge[g]),
      .fall_o (falling_edge[g]),
      .long_o (long_press[g]),
      .rep_o  (repeat_pulse[g])
    );
  end

  assign both_edge = rising_edge | falling_edge;

endmodule
